// File: rtl/run_seq_pkg.sv
// run_sequencer shared types.
// State encodings for the run-control FSM.
package run_seq_pkg;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    RUN    = 3'd2,
    STEP   = 3'd3,
    HALTED = 3'd4,
    FAULT  = 3'd5
  } state_t;
endpackage

// File: rtl/run_sequencer_if.sv
// Host loader / DataRAM port bundle.
// slave = sequencer side, master = host side.
interface run_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              host_mem_req;
  logic              host_mem_we;
  logic [ADDR_W-1:0] host_mem_addr;
  logic [DATA_W-1:0] host_mem_wdata;
  logic              host_mem_gnt;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;

  modport master (
    output host_mem_req, host_mem_we,
    output host_mem_addr, host_mem_wdata,
    input  host_mem_gnt,
    input  ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  host_mem_req, host_mem_we,
    input  host_mem_addr, host_mem_wdata,
    output host_mem_gnt,
    output ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/run_sequencer_ram_port_mux.sv
// DataRAM port arbiter: core when enabled,
// else host when allowed, else port idle.
module ram_port_mux #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              core_en,
  input  logic              host_ok,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              host_gnt
);
  logic host_sel;

  assign host_sel = host_ok & ~core_en;

  always_comb begin
    ram_addr  = core_addr;
    ram_wdata = core_wdata;
    ram_we    = 1'b0;
    host_gnt  = 1'b0;
    unique case (1'b1)
      core_en: ram_we = core_we;
      host_sel: begin
        ram_addr  = host_addr;
        ram_wdata = host_wdata;
        ram_we    = host_req & host_we;
        host_gnt  = host_req;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/run_sequencer.sv
// Run controller: init/run/step/halt FSM,
// retired-instruction watchdog, RAM sharing.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter int          DATA_W      = 16,
  parameter int          INIT_CYCLES = 2,
  parameter logic [15:0] MAX_INSTS   = 16'hFFFF
) (
  input  logic              CLK,
  input  logic              start,
  input  logic              go,
  input  logic              abort,
  input  logic              step_mode,
  input  logic              step,
  input  logic              core_halt,
  input  logic              core_mem_write,
  input  logic [ADDR_W-1:0] core_mem_addr,
  input  logic [DATA_W-1:0] core_mem_wdata,
  run_sequencer_if.slave    bus,
  output logic              core_init,
  output logic              core_en,
  output logic [2:0]        state,
  output logic [15:0]       inst_count,
  output logic              busy,
  output logic              done,
  output logic              timeout
);
  localparam logic [15:0] INIT_LAST =
    16'(INIT_CYCLES - 1);
  localparam logic [15:0] WD_LIMIT =
    MAX_INSTS - 16'd1;

  state_t      st;
  logic [15:0] init_cnt;
  logic [15:0] cnt_inc;
  logic        host_ok;
  logic        retire;
  logic        wd_hit;

  always_comb begin
    core_en   = 1'b0;
    core_init = 1'b0;
    host_ok   = 1'b0;
    case (st)
      IDLE: begin
        core_init = 1'b1;
        host_ok   = 1'b1;
      end
      INIT: core_init = 1'b1;
      RUN:  core_en = 1'b1;
      STEP: begin
        core_en = step & ~core_halt;
        host_ok = 1'b1;
      end
      HALTED, FAULT: host_ok = 1'b1;
      default: ;
    endcase
  end

  // The halt instruction itself never retires.
  assign retire  = core_en & ~core_halt;
  assign cnt_inc = (inst_count == 16'hFFFF) ?
                   inst_count : inst_count + 16'd1;
  assign wd_hit  = retire & (cnt_inc == WD_LIMIT);

  assign state   = st;
  assign busy    = (st == INIT) || (st == RUN) ||
                   (st == STEP);
  assign done    = (st == HALTED);
  assign timeout = (st == FAULT);

  always_ff @(posedge CLK) begin
    if (start) begin
      st         <= IDLE;
      inst_count <= '0;
      init_cnt   <= '0;
    end else begin
      if (retire) inst_count <= cnt_inc;
      if (abort) begin
        st <= IDLE;
      end else begin
        case (st)
          IDLE, HALTED, FAULT: begin
            if (go) begin
              st         <= INIT;
              inst_count <= '0;
              init_cnt   <= '0;
            end
          end
          INIT: begin
            if (init_cnt == INIT_LAST)
              st <= step_mode ? STEP : RUN;
            else
              init_cnt <= init_cnt + 16'd1;
          end
          RUN: begin
            if (core_halt)      st <= HALTED;
            else if (wd_hit)    st <= FAULT;
            else if (step_mode) st <= STEP;
          end
          STEP: begin
            if (core_halt)   st <= HALTED;
            else if (wd_hit) st <= FAULT;
            else if (!step_mode && !step)
              st <= RUN;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  ram_port_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .core_en   (core_en),
    .host_ok   (host_ok),
    .core_we   (core_mem_write),
    .core_addr (core_mem_addr),
    .core_wdata(core_mem_wdata),
    .host_req  (bus.host_mem_req),
    .host_we   (bus.host_mem_we),
    .host_addr (bus.host_mem_addr),
    .host_wdata(bus.host_mem_wdata),
    .ram_addr  (bus.ram_addr),
    .ram_we    (bus.ram_we),
    .ram_wdata (bus.ram_wdata),
    .host_gnt  (bus.host_mem_gnt)
  );
endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: default
// instance plus a MAX_INSTS=8 watchdog instance.
module tb_run_sequencer;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        start, go, abort, step_mode, step;
  logic        core_halt, core_mem_write;
  logic [15:0] core_mem_addr, core_mem_wdata;
  logic        h_req, h_we;
  logic [15:0] h_addr, h_wdata;

  logic        core_init, core_en, busy, done, timeout;
  logic [2:0]  state;
  logic [15:0] inst_count;

  logic        w_core_init, w_core_en;
  logic        w_busy, w_done, w_timeout;
  logic [2:0]  w_state;
  logic [15:0] w_inst_count;

  int vecs = 0;
  int errs = 0;

  run_sequencer_if bus ();
  run_sequencer_if wbus ();

  assign bus.host_mem_req    = h_req;
  assign bus.host_mem_we     = h_we;
  assign bus.host_mem_addr   = h_addr;
  assign bus.host_mem_wdata  = h_wdata;
  assign wbus.host_mem_req   = h_req;
  assign wbus.host_mem_we    = h_we;
  assign wbus.host_mem_addr  = h_addr;
  assign wbus.host_mem_wdata = h_wdata;

  run_sequencer dut (
    .CLK(CLK), .start(start), .go(go),
    .abort(abort), .step_mode(step_mode),
    .step(step), .core_halt(core_halt),
    .core_mem_write(core_mem_write),
    .core_mem_addr(core_mem_addr),
    .core_mem_wdata(core_mem_wdata),
    .bus(bus), .core_init(core_init),
    .core_en(core_en), .state(state),
    .inst_count(inst_count), .busy(busy),
    .done(done), .timeout(timeout)
  );

  run_sequencer #(.MAX_INSTS(16'd8)) dut_wd (
    .CLK(CLK), .start(start), .go(go),
    .abort(abort), .step_mode(step_mode),
    .step(step), .core_halt(core_halt),
    .core_mem_write(core_mem_write),
    .core_mem_addr(core_mem_addr),
    .core_mem_wdata(core_mem_wdata),
    .bus(wbus), .core_init(w_core_init),
    .core_en(w_core_en), .state(w_state),
    .inst_count(w_inst_count), .busy(w_busy),
    .done(w_done), .timeout(w_timeout)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic enter_run(input logic sm);
    step_mode = sm;
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    start = 1'b1;
    tick();
    start = 1'b0;
    vecs++;
    if (state !== 3'd0) begin
      errs++;
      $display("FAIL rst_state got %0d exp 0", state);
    end
    vecs++;
    if (inst_count !== 16'd0) begin
      errs++;
      $display("FAIL rst_count got %0d exp 0",
               inst_count);
    end
    vecs++;
    if ({core_init, core_en} !== 2'b10) begin
      errs++;
      $display("FAIL rst_init_en got %b exp 10",
               {core_init, core_en});
    end
    vecs++;
    if ({bus.host_mem_gnt, bus.ram_we} !== 2'b00) begin
      errs++;
      $display("FAIL rst_gnt_we got %b exp 00",
               {bus.host_mem_gnt, bus.ram_we});
    end
    vecs++;
    if ({busy, done, timeout} !== 3'b000) begin
      errs++;
      $display("FAIL rst_flags got %b exp 000",
               {busy, done, timeout});
    end
    vecs++;
    if (w_state !== 3'd0) begin
      errs++;
      $display("FAIL rst_wd_state got %0d exp 0",
               w_state);
    end
  endtask

  task automatic test_run_halt;
    step_mode = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vecs++;
      if ({state, core_init, busy} !== {3'd1, 2'b11}) begin
        errs++;
        $display("FAIL init_cyc%0d got %b exp 00111",
                 i, {state, core_init, busy});
      end
      tick();
    end
    for (int i = 0; i < 9; i++) begin
      vecs++;
      if ({state, core_en, core_init} !== {3'd2, 2'b10}) begin
        errs++;
        $display("FAIL run_cyc%0d got %b exp 01010",
                 i, {state, core_en, core_init});
      end
      tick();
    end
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    vecs++;
    if (state !== 3'd4) begin
      errs++;
      $display("FAIL halt_state got %0d exp 4", state);
    end
    vecs++;
    if (inst_count !== 16'd9) begin
      errs++;
      $display("FAIL halt_count got %0d exp 9",
               inst_count);
    end
    vecs++;
    if ({done, core_en, core_init} !== 3'b100) begin
      errs++;
      $display("FAIL halt_flags got %b exp 100",
               {done, core_en, core_init});
    end
  endtask

  task automatic test_arbitration;
    h_req = 1'b1;
    h_we = 1'b1;
    h_addr = 16'h0007;
    h_wdata = 16'hBEEF;
    step_mode = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    vecs++;
    if ({bus.host_mem_gnt, bus.ram_we} !== 2'b00) begin
      errs++;
      $display("FAIL init_host got %b exp 00",
               {bus.host_mem_gnt, bus.ram_we});
    end
    tick();
    tick();
    core_mem_write = 1'b1;
    core_mem_addr = 16'h0005;
    core_mem_wdata = 16'h1234;
    #1;
    vecs++;
    if (bus.ram_addr !== 16'h0005) begin
      errs++;
      $display("FAIL run_addr got %h exp 0005",
               bus.ram_addr);
    end
    vecs++;
    if (bus.ram_wdata !== 16'h1234) begin
      errs++;
      $display("FAIL run_wdata got %h exp 1234",
               bus.ram_wdata);
    end
    vecs++;
    if ({bus.ram_we, bus.host_mem_gnt} !== 2'b10) begin
      errs++;
      $display("FAIL run_we_gnt got %b exp 10",
               {bus.ram_we, bus.host_mem_gnt});
    end
    tick();
    core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    vecs++;
    if ({state, inst_count} !== {3'd4, 16'd1}) begin
      errs++;
      $display("FAIL arb_halt got st%0d n%0d exp st4 n1",
               state, inst_count);
    end
    vecs++;
    if (bus.ram_addr !== 16'h0007) begin
      errs++;
      $display("FAIL host_addr got %h exp 0007",
               bus.ram_addr);
    end
    vecs++;
    if (bus.ram_wdata !== 16'hBEEF) begin
      errs++;
      $display("FAIL host_wdata got %h exp beef",
               bus.ram_wdata);
    end
    vecs++;
    if ({bus.host_mem_gnt, bus.ram_we} !== 2'b11) begin
      errs++;
      $display("FAIL host_wr got %b exp 11",
               {bus.host_mem_gnt, bus.ram_we});
    end
    h_we = 1'b0;
    #1;
    vecs++;
    if ({bus.host_mem_gnt, bus.ram_we} !== 2'b10) begin
      errs++;
      $display("FAIL host_rd got %b exp 10",
               {bus.host_mem_gnt, bus.ram_we});
    end
    core_mem_write = 1'b0;
    h_req = 1'b0;
  endtask

  task automatic test_step;
    int en_seen;
    en_seen = 0;
    enter_run(1'b1);
    vecs++;
    if (state !== 3'd3) begin
      errs++;
      $display("FAIL step_state got %0d exp 3", state);
    end
    h_req = 1'b1;
    h_we = 1'b0;
    h_addr = 16'h0009;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 2; j++) begin
        #1;
        vecs++;
        if ({core_en, bus.host_mem_gnt} !== 2'b01) begin
          errs++;
          $display("FAIL step_idle%0d got %b exp 01",
                   k, {core_en, bus.host_mem_gnt});
        end
        if (core_en) en_seen++;
        tick();
      end
      step = 1'b1;
      #1;
      vecs++;
      if ({core_en, bus.host_mem_gnt} !== 2'b10) begin
        errs++;
        $display("FAIL step_pulse%0d got %b exp 10",
                 k, {core_en, bus.host_mem_gnt});
      end
      if (core_en) en_seen++;
      tick();
      step = 1'b0;
    end
    h_req = 1'b0;
    vecs++;
    if (en_seen !== 3) begin
      errs++;
      $display("FAIL step_en_cycles got %0d exp 3",
               en_seen);
    end
    vecs++;
    if ({state, inst_count} !== {3'd3, 16'd3}) begin
      errs++;
      $display("FAIL step_count got st%0d n%0d exp st3 n3",
               state, inst_count);
    end
  endtask

  task automatic test_halt_step;
    core_halt = 1'b1;
    step = 1'b1;
    #1;
    vecs++;
    if (core_en !== 1'b0) begin
      errs++;
      $display("FAIL hs_en got %b exp 0", core_en);
    end
    tick();
    core_halt = 1'b0;
    step = 1'b0;
    vecs++;
    if ({state, inst_count} !== {3'd4, 16'd3}) begin
      errs++;
      $display("FAIL hs_state got st%0d n%0d exp st4 n3",
               state, inst_count);
    end
  endtask

  task automatic test_watchdog;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    enter_run(1'b0);
    for (int i = 0; i < 7; i++) begin
      vecs++;
      if (w_state !== 3'd2) begin
        errs++;
        $display("FAIL wd_run%0d got %0d exp 2",
                 i, w_state);
      end
      tick();
    end
    vecs++;
    if ({w_state, w_timeout, w_core_en} !== {3'd5, 2'b10}) begin
      errs++;
      $display("FAIL wd_fault got %b exp 10110",
               {w_state, w_timeout, w_core_en});
    end
    vecs++;
    if (w_inst_count !== 16'd7) begin
      errs++;
      $display("FAIL wd_count got %0d exp 7",
               w_inst_count);
    end
    go = 1'b1;
    tick();
    go = 1'b0;
    vecs++;
    if ({w_state, w_inst_count} !== {3'd1, 16'd0}) begin
      errs++;
      $display("FAIL wd_rerun got st%0d n%0d exp st1 n0",
               w_state, w_inst_count);
    end
    vecs++;
    if ({state, inst_count} !== {3'd2, 16'd8}) begin
      errs++;
      $display("FAIL go_in_run got st%0d n%0d exp st2 n8",
               state, inst_count);
    end
  endtask

  task automatic test_abort_halt;
    abort = 1'b1;
    core_halt = 1'b1;
    tick();
    abort = 1'b0;
    core_halt = 1'b0;
    vecs++;
    if ({state, core_init, done} !== {3'd0, 2'b10}) begin
      errs++;
      $display("FAIL abort_halt got %b exp 00010",
               {state, core_init, done});
    end
  endtask

  task automatic test_start_midrun;
    enter_run(1'b0);
    tick();
    vecs++;
    if ({state, inst_count} !== {3'd2, 16'd1}) begin
      errs++;
      $display("FAIL mid_run got st%0d n%0d exp st2 n1",
               state, inst_count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    vecs++;
    if ({state, inst_count} !== {3'd0, 16'd0}) begin
      errs++;
      $display("FAIL srst_state got st%0d n%0d exp st0 n0",
               state, inst_count);
    end
    vecs++;
    if ({core_init, core_en, bus.host_mem_gnt,
         bus.ram_we, busy, done, timeout} !== 7'b1000000) begin
      errs++;
      $display("FAIL srst_outs got %b exp 1000000",
               {core_init, core_en, bus.host_mem_gnt,
                bus.ram_we, busy, done, timeout});
    end
  endtask

  initial begin
    start = 1'b0;
    go = 1'b0;
    abort = 1'b0;
    step_mode = 1'b0;
    step = 1'b0;
    core_halt = 1'b0;
    core_mem_write = 1'b0;
    core_mem_addr = '0;
    core_mem_wdata = '0;
    h_req = 1'b0;
    h_we = 1'b0;
    h_addr = '0;
    h_wdata = '0;
    test_reset();
    test_run_halt();
    test_arbitration();
    test_step();
    test_halt_step();
    test_watchdog();
    test_abort_halt();
    test_start_midrun();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
